// File: rtl/usb_pkg.sv
// Shared USB definitions: PID codes, transaction status and sequencer states.
package usb_pkg;

   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;

   typedef enum logic [1:0] {
      TXN_OK           = 2'b00,
      TXN_FAIL_TIMEOUT = 2'b01,
      TXN_FAIL_CORRUPT = 2'b10,
      TXN_FAIL_NAK     = 2'b11
   } txn_status_t;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_SEND_TOKEN = 3'd1,
      S_WAIT_RESP  = 3'd2,
      S_SEND_HS    = 3'd3,
      S_RETRY      = 3'd4,
      S_DONE       = 3'd5
   } txn_state_t;

endpackage

// File: rtl/txn_timer.sv
// Clear/enable saturating up-counter with a terminal-count flag.
module txn_timer #(
   parameter int W      = 8,
   parameter int TC_VAL = 254
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [W-1:0] count;

   // Count while enabled, hold at all-ones, clear has priority over enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

   assign tc = (count == W'(TC_VAL));

endmodule

// File: rtl/usb_in_txn_ctrl.sv
// Host-side USB IN transaction sequencer: token, response wait, handshake,
// retry budget and final status.
module usb_in_txn_ctrl
   import usb_pkg::*;
#(
   parameter int TIMEOUT_CYC  = 255,
   parameter int MAX_ATTEMPTS = 8,
   parameter int DATA_W       = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [6:0]        addr,
   input  logic [3:0]        endp,
   output logic              enc_req,
   output logic [3:0]        enc_pid,
   output logic [6:0]        enc_addr,
   output logic [3:0]        enc_endp,
   input  logic              enc_ack,
   input  logic              dec_avail,
   input  logic [3:0]        dec_pid,
   input  logic              dec_pid_ok,
   input  logic              dec_crc_ok,
   input  logic [DATA_W-1:0] dec_data,
   output logic              busy,
   output logic              done,
   output logic [1:0]        status,
   output logic [DATA_W-1:0] data_out
);

   localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);

   txn_state_t        state, state_nxt;
   txn_status_t       cause, status_q;
   logic [ATT_W-1:0]  attempts;
   logic              hs_ack;
   logic [6:0]        addr_q;
   logic [3:0]        endp_q;
   logic [DATA_W-1:0] data_q;
   logic              tmr_tc;
   logic              dec_clean;
   logic              dec_is_data;
   logic              last_attempt;

   assign dec_clean    = dec_pid_ok & dec_crc_ok;
   assign dec_is_data  = (dec_pid == PID_DATA0) || (dec_pid == PID_DATA1);
   assign last_attempt = (attempts == ATT_W'(MAX_ATTEMPTS));

   // Response timer restarts on every entry to WAIT_RESP (the token ack).
   txn_timer #(
      .W      (TMR_W),
      .TC_VAL (TIMEOUT_CYC - 1)
   ) u_timer (
      .clk (clk),
      .rst (rst),
      .clr ((state == S_SEND_TOKEN) && enc_ack),
      .en  (state == S_WAIT_RESP),
      .tc  (tmr_tc)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and state-decoded encoder/handshake outputs.
   always_comb begin
      state_nxt = state;
      enc_req   = 1'b0;
      enc_pid   = 4'b0000;
      done      = 1'b0;
      busy      = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_SEND_TOKEN;
         end
         S_SEND_TOKEN: begin
            enc_req = 1'b1;
            enc_pid = PID_IN;
            if (enc_ack) state_nxt = S_WAIT_RESP;
         end
         S_WAIT_RESP: begin
            // A packet arriving in the timeout cycle takes precedence.
            if (dec_avail) begin
               if (!dec_clean || dec_is_data) state_nxt = S_SEND_HS;
               else                           state_nxt = S_RETRY;
            end else if (tmr_tc) begin
               state_nxt = S_RETRY;
            end
         end
         S_SEND_HS: begin
            enc_req = 1'b1;
            enc_pid = hs_ack ? PID_ACK : PID_NAK;
            if (enc_ack) state_nxt = hs_ack ? S_DONE : S_RETRY;
         end
         S_RETRY: begin
            state_nxt = last_attempt ? S_DONE : S_SEND_TOKEN;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Latched request fields, attempt budget, response outcome and result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q   <= '0;
         endp_q   <= '0;
         attempts <= '0;
         cause    <= TXN_OK;
         hs_ack   <= 1'b0;
         status_q <= TXN_OK;
         data_q   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  addr_q   <= addr;
                  endp_q   <= endp;
                  attempts <= ATT_W'(1);
                  status_q <= TXN_OK;
               end
            end
            S_WAIT_RESP: begin
               if (dec_avail) begin
                  if (dec_clean && dec_is_data) begin
                     data_q <= dec_data;
                     cause  <= TXN_OK;
                     hs_ack <= 1'b1;
                  end else if (!dec_clean) begin
                     cause  <= TXN_FAIL_CORRUPT;
                     hs_ack <= 1'b0;
                  end else if (dec_pid == PID_NAK) begin
                     cause  <= TXN_FAIL_NAK;
                  end else begin
                     cause  <= TXN_FAIL_CORRUPT;
                  end
               end else if (tmr_tc) begin
                  cause <= TXN_FAIL_TIMEOUT;
               end
            end
            S_SEND_HS: begin
               if (enc_ack && hs_ack) status_q <= TXN_OK;
            end
            S_RETRY: begin
               if (last_attempt) status_q <= cause;
               else              attempts <= attempts + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign enc_addr = addr_q;
   assign enc_endp = endp_q;
   assign status   = status_q;
   assign data_out = data_q;

endmodule

// File: tb/tb_usb_in_txn_ctrl.sv
// Directed testbench for usb_in_txn_ctrl.
module tb_usb_in_txn_ctrl;

   localparam logic [3:0] P_IN    = 4'b1001;
   localparam logic [3:0] P_DATA0 = 4'b0011;
   localparam logic [3:0] P_DATA1 = 4'b1011;
   localparam logic [3:0] P_ACK   = 4'b0010;
   localparam logic [3:0] P_NAK   = 4'b1010;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [6:0]  addr;
   logic [3:0]  endp;
   logic        enc_req;
   logic [3:0]  enc_pid;
   logic [6:0]  enc_addr;
   logic [3:0]  enc_endp;
   logic        enc_ack;
   logic        dec_avail;
   logic [3:0]  dec_pid;
   logic        dec_pid_ok;
   logic        dec_crc_ok;
   logic [63:0] dec_data;
   logic        busy;
   logic        done;
   logic [1:0]  status;
   logic [63:0] data_out;

   int checks = 0;
   int errors = 0;
   int tok_cnt = 0;
   int hs_cnt = 0;

   usb_in_txn_ctrl #(
      .TIMEOUT_CYC  (255),
      .MAX_ATTEMPTS (8),
      .DATA_W       (64)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .addr       (addr),
      .endp       (endp),
      .enc_req    (enc_req),
      .enc_pid    (enc_pid),
      .enc_addr   (enc_addr),
      .enc_endp   (enc_endp),
      .enc_ack    (enc_ack),
      .dec_avail  (dec_avail),
      .dec_pid    (dec_pid),
      .dec_pid_ok (dec_pid_ok),
      .dec_crc_ok (dec_crc_ok),
      .dec_data   (dec_data),
      .busy       (busy),
      .done       (done),
      .status     (status),
      .data_out   (data_out)
   );

   always #5 clk = ~clk;

   // Tally completed encoder transfers: IN tokens versus host handshakes.
   always @(posedge clk) begin
      if (!rst && enc_req && enc_ack) begin
         if (enc_pid == P_IN) tok_cnt = tok_cnt + 1;
         else                 hs_cnt  = hs_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [6:0] a, input logic [3:0] e);
      start = 1'b1;
      addr  = a;
      endp  = e;
      tick();
      start = 1'b0;
   endtask

   // Wait (bounded) for an encoder request, check it, then acknowledge it.
   task automatic enc_hs(input string tag, input logic [3:0] pid, input logic [6:0] ea,
                         input logic [3:0] ee, input int max, output int waited);
      waited = 0;
      while (!enc_req && waited < max) begin
         tick();
         waited++;
      end
      chk({tag, "_req"}, {63'd0, enc_req}, 64'd1);
      chk({tag, "_pid"}, {60'd0, enc_pid}, {60'd0, pid});
      if (pid == P_IN) begin
         chk({tag, "_addr"}, {57'd0, enc_addr}, {57'd0, ea});
         chk({tag, "_endp"}, {60'd0, enc_endp}, {60'd0, ee});
      end
      enc_ack = 1'b1;
      tick();
      enc_ack = 1'b0;
      chk({tag, "_drop"}, {63'd0, enc_req}, 64'd0);
   endtask

   task automatic dec_send(input logic [3:0] pid, input logic pok, input logic cok,
                           input logic [63:0] d);
      dec_avail  = 1'b1;
      dec_pid    = pid;
      dec_pid_ok = pok;
      dec_crc_ok = cok;
      dec_data   = d;
      tick();
      dec_avail  = 1'b0;
      dec_data   = '0;
   endtask

   // Wait (bounded) for done, check final status, then check busy drops.
   task automatic wait_done(input string tag, input int max, input logic [1:0] st);
      int n = 0;
      while (!done && n < max) begin
         tick();
         n++;
      end
      chk({tag, "_done"}, {63'd0, done}, 64'd1);
      chk({tag, "_status"}, {62'd0, status}, {62'd0, st});
      chk({tag, "_busy_done"}, {63'd0, busy}, 64'd1);
      tick();
      chk({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
      chk({tag, "_done_after"}, {63'd0, done}, 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      int base_t;
      int base_h;
      rst = 1'b1; start = 1'b0; addr = '0; endp = '0; enc_ack = 1'b0;
      dec_avail = 1'b0; dec_pid = '0; dec_pid_ok = 1'b0; dec_crc_ok = 1'b0; dec_data = '0;
      tick(); tick();
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_enc_req", {63'd0, enc_req}, 64'd0);
      chk("rst_status", {62'd0, status}, 64'd0);
      chk("rst_data", data_out, 64'd0);
      rst = 1'b0;
      tick();

      // Stray pulses while idle do nothing.
      dec_avail = 1'b1; enc_ack = 1'b1; dec_pid = P_DATA0; dec_pid_ok = 1'b1; dec_crc_ok = 1'b1;
      tick();
      dec_avail = 1'b0; enc_ack = 1'b0;
      chk("stray_busy", {63'd0, busy}, 64'd0);
      chk("stray_req", {63'd0, enc_req}, 64'd0);

      // Good path.
      base_t = tok_cnt; base_h = hs_cnt;
      do_start(7'h05, 4'h4);
      chk("good_busy", {63'd0, busy}, 64'd1);
      enc_hs("good_in", P_IN, 7'h05, 4'h4, 10, w);
      chk("good_in_wait", w, 0);
      tick(); tick();
      dec_send(P_DATA0, 1'b1, 1'b1, 64'hCAFE_F00D_DEAD_BEEF);
      dec_send(P_NAK, 1'b1, 1'b1, 64'h1);
      enc_hs("good_ack", P_ACK, 7'h05, 4'h4, 10, w);
      chk("good_data", data_out, 64'hCAFE_F00D_DEAD_BEEF);
      wait_done("good", 5, 2'b00);
      chk("good_tokens", tok_cnt - base_t, 1);
      chk("good_hs", hs_cnt - base_h, 1);

      // CRC error then good DATA1; a start while busy is ignored.
      base_t = tok_cnt; base_h = hs_cnt;
      do_start(7'h11, 4'h2);
      enc_hs("crc_in1", P_IN, 7'h11, 4'h2, 10, w);
      start = 1'b1; addr = 7'h7F; endp = 4'hF;
      tick();
      start = 1'b0;
      dec_send(P_DATA0, 1'b1, 1'b0, 64'hBAD0_BAD0_BAD0_BAD0);
      enc_hs("crc_nak", P_NAK, 7'h11, 4'h2, 10, w);
      enc_hs("crc_in2", P_IN, 7'h11, 4'h2, 10, w);
      dec_send(P_DATA1, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF);
      enc_hs("crc_ack", P_ACK, 7'h11, 4'h2, 10, w);
      wait_done("crc", 5, 2'b00);
      chk("crc_data", data_out, 64'h0123_4567_89AB_CDEF);
      chk("crc_tokens", tok_cnt - base_t, 2);
      chk("crc_hs", hs_cnt - base_h, 2);

      // Silent device: eight tokens spaced by the timeout, then FAIL_TIMEOUT.
      base_t = tok_cnt; base_h = hs_cnt;
      do_start(7'h22, 4'h1);
      for (int i = 0; i < 8; i++) begin
         enc_hs("sil_in", P_IN, 7'h22, 4'h1, 400, w);
         if (i == 1) chk("sil_spacing", w, 256);
      end
      wait_done("sil", 400, 2'b01);
      chk("sil_tokens", tok_cnt - base_t, 8);
      chk("sil_hs", hs_cnt - base_h, 0);

      // Device NAKs every attempt.
      base_t = tok_cnt; base_h = hs_cnt;
      do_start(7'h33, 4'h3);
      for (int i = 0; i < 8; i++) begin
         enc_hs("nak_in", P_IN, 7'h33, 4'h3, 10, w);
         tick();
         dec_send(P_NAK, 1'b1, 1'b1, 64'h0);
      end
      wait_done("nak", 5, 2'b11);
      chk("nak_tokens", tok_cnt - base_t, 8);
      chk("nak_hs", hs_cnt - base_h, 0);

      // Good DATA0 exactly in the timeout cycle.
      base_t = tok_cnt; base_h = hs_cnt;
      do_start(7'h44, 4'h5);
      enc_hs("race_in", P_IN, 7'h44, 4'h5, 10, w);
      repeat (254) tick();
      dec_send(P_DATA0, 1'b1, 1'b1, 64'h5555_AAAA_5555_AAAA);
      enc_hs("race_ack", P_ACK, 7'h44, 4'h5, 2, w);
      chk("race_wait", w, 0);
      wait_done("race", 5, 2'b00);
      chk("race_data", data_out, 64'h5555_AAAA_5555_AAAA);
      chk("race_tokens", tok_cnt - base_t, 1);

      // Reset in WAIT_RESP clears everything at once; next run starts fresh.
      do_start(7'h66, 4'h6);
      enc_hs("rst_in", P_IN, 7'h66, 4'h6, 10, w);
      tick(); tick();
      rst = 1'b1;
      #1;
      chk("mid_busy", {63'd0, busy}, 64'd0);
      chk("mid_req", {63'd0, enc_req}, 64'd0);
      chk("mid_pid", {60'd0, enc_pid}, 64'd0);
      chk("mid_addr", {57'd0, enc_addr}, 64'd0);
      chk("mid_endp", {60'd0, enc_endp}, 64'd0);
      chk("mid_data", data_out, 64'd0);
      chk("mid_status", {62'd0, status}, 64'd0);
      chk("mid_done", {63'd0, done}, 64'd0);
      tick();
      rst = 1'b0;
      tick();
      base_t = tok_cnt; base_h = hs_cnt;
      do_start(7'h77, 4'h7);
      for (int i = 0; i < 8; i++) begin
         enc_hs("post_in", P_IN, 7'h77, 4'h7, 10, w);
         dec_send(P_NAK, 1'b1, 1'b1, 64'h0);
      end
      wait_done("post", 5, 2'b11);
      chk("post_tokens", tok_cnt - base_t, 8);
      chk("post_hs", hs_cnt - base_h, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/usb_in_txn_ctrl.md
Name: usb_in_txn_ctrl

Overview:
Host-side sequencer for a USB IN transaction. It commands the packet encoder to send an IN token, then waits for the CRC/PID-checking decoder to deliver the device's response. Depending on that response it commands the encoder to send an ACK or NAK handshake. It owns the response timeout, the retry budget and the final transaction status, and sits between the host's transaction-request interface and the encoder/decoder pair.

Parameters:
TIMEOUT_CYC, 255, cycles to wait in WAIT_RESP before declaring a timeout
MAX_ATTEMPTS, 8, total IN tokens sent before the transaction fails
DATA_W, 64, payload width delivered by the decoder

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  single-cycle request for a new IN transaction; ignored unless idle
addr  in  7  device address, latched on accepted start
endp  in  4  endpoint, latched on accepted start
enc_req  out  1  request to encoder; held until enc_ack
enc_pid  out  4  PID for encoder (IN=4'b1001, ACK=4'b0010, NAK=4'b1010)
enc_addr  out  7  latched addr, valid while enc_req and PID is IN
enc_endp  out  4  latched endp, valid while enc_req and PID is IN
enc_ack  in  1  encoder finished sending, single-cycle pulse
dec_avail  in  1  decoder packet complete, single-cycle pulse
dec_pid  in  4  decoded PID, valid with dec_avail
dec_pid_ok  in  1  PID equals complement of nPID field, valid with dec_avail
dec_crc_ok  in  1  residue check passed, valid with dec_avail
dec_data  in  DATA_W  payload, valid with dec_avail
busy  out  1  high from accepted start until the cycle after done
done  out  1  single-cycle pulse at end of transaction
status  out  2  00 OK, 01 FAIL_TIMEOUT, 10 FAIL_CORRUPT, 11 FAIL_NAK; last failure cause, stable until next start
data_out  out  DATA_W  payload of accepted DATA packet, stable until next start

Behaviour:
- Reset (asynchronous, any state): state = IDLE. All outputs are 0, including status, data_out, enc_pid, enc_addr and enc_endp. The attempt counter and timer are cleared.
- States: IDLE, SEND_TOKEN, WAIT_RESP, SEND_HS, RETRY, DONE.
- IDLE
  - On start: latch addr/endp, set attempts = 1, busy = 1, go to SEND_TOKEN.
  - start is ignored in every other state.
- SEND_TOKEN
  - enc_req = 1, enc_pid = IN.
  - On enc_ack: clear timer, go to WAIT_RESP next cycle.
  - enc_req drops in the cycle after enc_ack.
- WAIT_RESP: timer increments every cycle.
  - dec_avail with pid_ok & crc_ok & PID in {DATA0 4'b0011, DATA1 4'b1011}: latch dec_data into data_out, set pending result = OK, handshake = ACK, go to SEND_HS.
  - dec_avail with !pid_ok or !crc_ok: cause = CORRUPT, handshake = NAK, go to SEND_HS.
  - dec_avail with a clean NAK PID: cause = NAK, go to RETRY (the host sends no handshake).
  - dec_avail with any other clean PID: cause = CORRUPT, go to RETRY.
  - Timer == TIMEOUT_CYC-1 with no dec_avail: cause = TIMEOUT, go to RETRY.
  - dec_avail in the same cycle as the timeout: the packet wins.
- SEND_HS
  - enc_req = 1, enc_pid = ACK or NAK.
  - On enc_ack: ACK goes to DONE with status OK; NAK goes to RETRY.
  - dec_avail is ignored here.
- RETRY (one cycle)
  - If attempts == MAX_ATTEMPTS: status = cause, go to DONE.
  - Otherwise: attempts += 1, go to SEND_TOKEN.
- DONE (one cycle)
  - done = 1, go to IDLE.
  - busy drops in the cycle after done.
- Latency: the minimum from start to done with a good DATA response is 4 cycles plus encoder and device latency.
- Counters
  - attempts is $clog2(MAX_ATTEMPTS+1) bits and never wraps.
  - The timer is $clog2(TIMEOUT_CYC) bits, saturates, and clears on every entry to WAIT_RESP.
- Stray pulses: dec_avail or enc_ack outside its waiting state has no effect.
- Reset mid-transaction: the transaction is abandoned, no done pulse, status = 00.

Decomposition:
- Package usb_pkg holds:
  - the PID localparams (IN, DATA0, DATA1, ACK, NAK, STALL);
  - the txn_status_t enum (OK, FAIL_TIMEOUT, FAIL_CORRUPT, FAIL_NAK);
  - the state enum.
- One natural sub-module, txn_timer: a clear/enable saturating counter with a terminal-count output, reused for the timeout.

Test Plan:
- Good path: start (addr=7'h05, endp=4'h4) -> enc_req with IN; ack; DATA0 with pid_ok=crc_ok=1, data=64'hCAFE... -> enc_pid=ACK; ack -> done=1, status=00, data_out=64'hCAFE..., attempts used = 1.
- CRC error then good: first response crc_ok=0 -> NAK sent, second IN token issued, then good DATA1 -> ACK, status=00, exactly 2 IN tokens seen.
- Silent device: no dec_avail ever -> 8 IN tokens spaced by TIMEOUT_CYC cycles, then done with status=01 and no handshake sent.
- Device NAKs every time -> 8 tokens, no host handshake, status=11.
- Race: dec_avail with a good DATA0 in exactly the timeout cycle -> treated as data; ACK sent, status=00.
- Reset asserted in WAIT_RESP -> all outputs are 0 immediately; a new start after deassertion runs a clean transaction with the attempt count back at 1.
